// File: rtl/ls_pkg.sv
// Shared types and sizing for the load/store issue station.
package ls_pkg;
  localparam int DEPTH  = 4;
  localparam int ROB_W  = 4;
  localparam int PREG_W = 6;
  localparam int PTR_W  = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic              st;
    logic              ld;
    logic [PREG_W-1:0] p_rs;
    logic              rs_rdy;
    logic [31:0]       rs_val;
    logic [PREG_W-1:0] p_rt;
    logic              rt_rdy;
    logic [31:0]       rt_val;
    logic [15:0]       immed;
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] p_rd;
  } ls_entry_t;

  // Distance of a ROB tag from the current ROB head; larger means younger.
  function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] tag,
                                               input logic [ROB_W-1:0] head);
    logic [ROB_W-1:0] a;
    a = tag - head;
    return a;
  endfunction
endpackage

// File: rtl/ls_operand_wakeup.sv
// Single-operand CDB snoop: captures the broadcast value when the tag matches a pending operand.
module ls_operand_wakeup
  import ls_pkg::*;
(
  input  logic              en,
  input  logic              rdy,
  input  logic [PREG_W-1:0] tag,
  input  logic [31:0]       val,
  input  logic              cdb_valid,
  input  logic [PREG_W-1:0] cdb_preg,
  input  logic [31:0]       cdb_data,
  output logic              rdy_nxt,
  output logic [31:0]       val_nxt
);
  logic hit;

  assign hit     = en && !rdy && cdb_valid && (tag == cdb_preg);
  assign rdy_nxt = rdy | hit;
  assign val_nxt = hit ? cdb_data : val;
endmodule

// File: rtl/ls_issue_station.sv
// In-order load/store reservation station in front of the store queue.
// Optional LS_STALL_CNT_EN adds a saturating count of cycles lost only to sq_full.
module ls_issue_station
  import ls_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              dispatch,
  input  logic              d_mem_wen,
  input  logic              d_mem_ren,
  input  logic [PREG_W-1:0] d_p_rs,
  input  logic              d_rs_rdy,
  input  logic [31:0]       d_rs_val,
  input  logic [PREG_W-1:0] d_p_rt,
  input  logic              d_rt_rdy,
  input  logic [31:0]       d_rt_val,
  input  logic [15:0]       d_immed,
  input  logic [ROB_W-1:0]  d_rob,
  input  logic [PREG_W-1:0] d_p_rd,
  input  logic              cdb_valid,
  input  logic [PREG_W-1:0] cdb_preg,
  input  logic [31:0]       cdb_data,
  input  logic [ROB_W-1:0]  rob_head,
  input  logic              recover,
  input  logic [ROB_W-1:0]  rec_rob,
  input  logic              stall_hazard,
  input  logic              sq_full,
  output logic              ls_full,
  output logic              issue,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [31:0]       rs_data,
  output logic [31:0]       rt_data,
  output logic [15:0]       immed,
  output logic [ROB_W-1:0]  rob_out,
`ifdef LS_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [PREG_W-1:0] p_rd_out
);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  ls_entry_t [DEPTH-1:0]        ent;
  logic [PTR_W-1:0]             head, tail;
  logic [PTR_W:0]               count, surv;
  logic [DEPTH-1:0]             rs_rdy_nxt, rt_rdy_nxt, squash;
  logic [DEPTH-1:0][31:0]       rs_val_nxt, rt_val_nxt;
  logic                         d_rs_rdy_w, d_rt_rdy_w;
  logic [31:0]                  d_rs_val_w, d_rt_val_w;
  ls_entry_t                    d_ent;
  logic                         head_rdy, accept;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    ls_operand_wakeup u_rs (
      .en(ent[g].valid), .rdy(ent[g].rs_rdy), .tag(ent[g].p_rs), .val(ent[g].rs_val),
      .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .cdb_data(cdb_data),
      .rdy_nxt(rs_rdy_nxt[g]), .val_nxt(rs_val_nxt[g])
    );
    ls_operand_wakeup u_rt (
      .en(ent[g].valid), .rdy(ent[g].rt_rdy), .tag(ent[g].p_rt), .val(ent[g].rt_val),
      .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .cdb_data(cdb_data),
      .rdy_nxt(rt_rdy_nxt[g]), .val_nxt(rt_val_nxt[g])
    );
    assign squash[g] = ent[g].valid &&
                       (rob_age(ent[g].rob, rob_head) >= rob_age(rec_rob, rob_head));
  end

  // Dispatching op snoops the same-cycle CDB so a coincident broadcast is not lost.
  ls_operand_wakeup u_d_rs (
    .en(dispatch), .rdy(d_rs_rdy), .tag(d_p_rs), .val(d_rs_val),
    .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .cdb_data(cdb_data),
    .rdy_nxt(d_rs_rdy_w), .val_nxt(d_rs_val_w)
  );
  ls_operand_wakeup u_d_rt (
    .en(dispatch), .rdy(d_rt_rdy), .tag(d_p_rt), .val(d_rt_val),
    .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .cdb_data(cdb_data),
    .rdy_nxt(d_rt_rdy_w), .val_nxt(d_rt_val_w)
  );

  always_comb begin
    d_ent        = '0;
    d_ent.valid  = 1'b1;
    d_ent.st     = d_mem_wen;
    d_ent.ld     = d_mem_ren;
    d_ent.p_rs   = d_p_rs;
    d_ent.rs_rdy = d_rs_rdy_w;
    d_ent.rs_val = d_rs_val_w;
    d_ent.p_rt   = d_p_rt;
    d_ent.rt_rdy = d_rt_rdy_w;
    d_ent.rt_val = d_rt_val_w;
    d_ent.immed  = d_immed;
    d_ent.rob    = d_rob;
    d_ent.p_rd   = d_p_rd;
  end

  always_comb begin
    surv = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent[i].valid && !squash[i]) surv = surv + CNT_ONE;
  end

  assign ls_full  = (count == CNT_FULL);
  assign accept   = dispatch && !ls_full && !recover;
  assign head_rdy = ent[head].valid && ent[head].rs_rdy && (ent[head].ld || ent[head].rt_rdy);
  assign issue    = head_rdy && !stall_hazard && !recover && !(ent[head].st && sq_full);

  assign mem_wen  = issue & ent[head].st;
  assign mem_ren  = issue & ent[head].ld;
  assign rs_data  = issue ? ent[head].rs_val : '0;
  assign rt_data  = issue ? ent[head].rt_val : '0;
  assign immed    = issue ? ent[head].immed  : '0;
  assign rob_out  = issue ? ent[head].rob    : '0;
  assign p_rd_out = issue ? ent[head].p_rd   : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].rs_rdy <= rs_rdy_nxt[i];
        ent[i].rs_val <= rs_val_nxt[i];
        ent[i].rt_rdy <= rt_rdy_nxt[i];
        ent[i].rt_val <= rt_val_nxt[i];
        if (recover && squash[i]) ent[i].valid <= 1'b0;
      end
      if (recover) begin
        // Program order makes the squashed set a tail suffix, so survivors stay contiguous.
        tail  <= head + surv[PTR_W-1:0];
        count <= surv;
      end else begin
        if (issue) begin
          ent[head].valid <= 1'b0;
          head            <= head + PTR_ONE;
        end
        if (accept) begin
          ent[tail] <= d_ent;
          tail      <= tail + PTR_ONE;
        end
        case ({accept, issue})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef LS_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_q <= '0;
    else if (head_rdy && ent[head].st && sq_full && !stall_hazard && !recover &&
             stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`endif
endmodule
